// File: rtl/dsp_pkg.sv
// Shared DSP library definitions: coefficient-loader state encoding and frame sizing.
// Holds no logic; it is imported by the loader and any block that needs the frame length.
package dsp_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    PEND = 1'b1
  } load_state_e;

  // A direct form I frame carries b0..bN followed by -a1..-aN.
  function automatic int frame_len(input int order);
    return 2 * order + 1;
  endfunction

endpackage

// File: rtl/iir_coeff_loader.sv
// Streams a 2N+1 word coefficient frame into a shadow bank and commits it atomically on swap_en.
// Commit is visible one edge after swap_en is sampled in PEND; s_ready drops from last word until commit.
module iir_coeff_loader
  import dsp_pkg::*;
#(
  parameter int N           = 2,
  parameter int COEFF_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [COEFF_WIDTH-1:0]     s_data,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  input  logic                       swap_en,
  input  logic                       abort,
  output logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
  output logic [COEFF_WIDTH*N-1:0]   packed_a_coeffs,
  output logic                       coeffs_valid,
  output logic                       updated,
  output logic                       frame_err
);

  localparam int M     = frame_len(N);
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(M - 1);

  load_state_e              state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [COEFF_WIDTH-1:0]   shadow_q [M];
  logic [COEFF_WIDTH-1:0]   active_q [M];
  logic                     accept;
  logic                     commit;
  logic                     err_d;

  // Ready depends only on registered state, abort and reset; never on s_valid.
  assign s_ready = rst_n && !abort && (state_q == LOAD);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    if (abort) begin
      state_d = LOAD;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (s_last && idx_q == IDX_LAST) begin
              state_d = PEND;
              idx_d   = '0;
            end else if (s_last || idx_q == IDX_LAST) begin
              err_d = 1'b1;
              idx_d = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        PEND: begin
          if (swap_en) begin
            commit  = 1'b1;
            state_d = LOAD;
          end
        end
        default: begin
          state_d = LOAD;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      coeffs_valid <= 1'b0;
      updated      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      coeffs_valid <= coeffs_valid | commit;
      updated      <= commit;
      frame_err    <= err_d;
    end
  end

  // Shadow slots are written by index compare so idx never addresses past M-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < M; i++) begin
        if (accept && idx_q == IDX_W'(i)) shadow_q[i] <= s_data;
        if (commit) active_q[i] <= shadow_q[i];
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k <= N; k++) begin : g_pack_b
      assign packed_b_coeffs[COEFF_WIDTH*k +: COEFF_WIDTH] = active_q[k];
    end
    for (k = 1; k <= N; k++) begin : g_pack_a
      assign packed_a_coeffs[COEFF_WIDTH*(k-1) +: COEFF_WIDTH] = active_q[N+k];
    end
  endgenerate

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed-vector scoreboard bench for iir_coeff_loader (N=2, 16-bit words).
// Stimulus pushes expected commits/errors; a monitor pops them on updated/frame_err pulses.
module tb_iir_coeff_loader;

  localparam int N  = 2;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CW-1:0]     s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic              swap_en = 1'b0;
  logic              abort = 1'b0;
  logic [CW*3-1:0]   packed_b_coeffs;
  logic [CW*2-1:0]   packed_a_coeffs;
  logic              coeffs_valid;
  logic              updated;
  logic              frame_err;

  typedef struct {
    bit          is_err;
    logic [47:0] b;
    logic [31:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  iir_coeff_loader #(.N(N), .COEFF_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_last          (s_last),
    .s_ready         (s_ready),
    .swap_en         (swap_en),
    .abort           (abort),
    .packed_b_coeffs (packed_b_coeffs),
    .packed_a_coeffs (packed_a_coeffs),
    .coeffs_valid    (coeffs_valid),
    .updated         (updated),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_commit(input logic [47:0] b, input logic [31:0] a);
    exp_t e;
    e.is_err = 1'b0;
    e.b = b;
    e.a = a;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.b = '0;
    e.a = '0;
    exp_q.push_back(e);
  endtask

  // Entered and left just after a rising edge; gaps drive junk data with s_valid low.
  task automatic send_word(input logic [CW-1:0] d, input logic last, input int gap);
    int waited;
    bit hs;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      s_data  = 16'hDEAD;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    waited  = 0;
    hs      = 1'b0;
    while (!hs && waited < 20) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk); #1;
      waited++;
    end
    if (!hs) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: got s_ready=0 for %0d cycles expected accept", waited);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 16'hBEEF;
  endtask

  task automatic send_frame(input logic [79:0] w, input int max_gap);
    for (int i = 0; i < 5; i++)
      send_word(w[16*i +: 16], (i == 4), (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
  endtask

  // Monitor: every updated/frame_err pulse must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (updated || frame_err)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got updated=%b frame_err=%b expected none", updated, frame_err);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {62'd0, updated, frame_err}, {62'd0, !e.is_err, e.is_err});
          if (!e.is_err) begin
            chk("commit_b", {16'd0, packed_b_coeffs}, {16'd0, e.b});
            chk("commit_a", {32'd0, packed_a_coeffs}, {32'd0, e.a});
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_b", {16'd0, packed_b_coeffs}, 64'd0);
    chk("rst_a", {32'd0, packed_a_coeffs}, 64'd0);
    chk("rst_flags", {61'd0, coeffs_valid, updated, frame_err}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;

    // First frame, swap_en arrives in the third PEND cycle
    send_frame({16'hE000, 16'h6000, 16'h4000, 16'h8000, 16'h4000}, 0);
    @(negedge clk); chk("pend_ready_1", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("pend_ready_2", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    swap_en = 1'b1;
    push_commit(48'h4000_8000_4000, 32'hE000_6000);
    @(negedge clk); chk("pend_ready_3", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    swap_en = 1'b0;
    @(negedge clk);
    chk("ready_after_commit", {63'd0, s_ready}, 64'd1);
    chk("coeffs_valid_1", {63'd0, coeffs_valid}, 64'd1);
    @(posedge clk); #1;

    // Short frame: s_last on word 3
    send_word(16'h0AAA, 1'b0, 0);
    send_word(16'h0BBB, 1'b0, 0);
    push_err();
    send_word(16'h0CCC, 1'b1, 0);
    @(negedge clk);
    chk("err_stays_load", {63'd0, s_ready}, 64'd1);
    chk("err_b_unchanged", {16'd0, packed_b_coeffs}, {16'd0, 48'h4000_8000_4000});
    chk("err_a_unchanged", {32'd0, packed_a_coeffs}, {32'd0, 32'hE000_6000});
    @(posedge clk); #1;

    // Long frame: no s_last on word 5
    for (int i = 0; i < 4; i++) send_word(16'h0F00 + 16'(i), 1'b0, 0);
    push_err();
    send_word(16'h0F04, 1'b0, 0);

    // Good frame, committed with minimum latency
    send_frame({16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0);
    swap_en = 1'b1;
    push_commit(48'h3333_2222_1111, 32'h5555_4444);
    @(posedge clk); #1;
    swap_en = 1'b0;
    @(negedge clk);
    chk("minlat_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;

    // Complete frame, then abort with swap_en in the same cycle
    send_frame({16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA}, 0);
    abort   = 1'b1;
    swap_en = 1'b1;
    @(negedge clk); chk("abort_ready_low", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    abort   = 1'b0;
    swap_en = 1'b0;
    @(negedge clk);
    chk("abort_ready_next", {63'd0, s_ready}, 64'd1);
    chk("abort_b_unchanged", {16'd0, packed_b_coeffs}, {16'd0, 48'h3333_2222_1111});
    @(posedge clk); #1;
    swap_en = 1'b1;  // ignored in LOAD
    @(posedge clk); #1;
    swap_en = 1'b0;

    // Random s_valid gaps; hold in PEND before committing
    send_frame({16'h1234, 16'h8001, 16'hFFFF, 16'h0001, 16'h7FFF}, 3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("gap_hold_b", {16'd0, packed_b_coeffs}, {16'd0, 48'h3333_2222_1111});
    chk("gap_hold_ready", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    swap_en = 1'b1;
    push_commit(48'hFFFF_0001_7FFF, 32'h1234_8001);
    @(posedge clk); #1;
    swap_en = 1'b0;

    // Asynchronous reset mid-frame
    send_word(16'h7777, 1'b0, 0);
    send_word(16'h6666, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_b", {16'd0, packed_b_coeffs}, 64'd0);
    chk("async_rst_a", {32'd0, packed_a_coeffs}, 64'd0);
    chk("async_rst_valid", {63'd0, coeffs_valid}, 64'd0);
    @(negedge clk); chk("async_rst_ready", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame({16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101}, 1);
    swap_en = 1'b1;
    push_commit(48'h0103_0102_0101, 32'h0105_0104);
    @(posedge clk); #1;
    swap_en = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {63'd0, coeffs_valid}, 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
